// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction-fetch stage.
//   PC_W       : program-counter width
//   INSTR_W    : instruction width
//   NOP_INSTR  : bubble instruction (addi x0,x0,0)
//   fetch_state_t : fetch FSM states
package fetch_pkg;

  localparam int unsigned PC_W    = 16;
  localparam int unsigned INSTR_W = 32;

  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    REQ  = 2'd0,
    WAIT = 2'd1,
    HOLD = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/fetch_pipeline.sv
// Instruction-fetch stage plus IF/ID pipeline register.
// Ports:
//   clk, reset (async, active-high)
//   pc_write_zero, IF_pipeline_write_zero : hazard-unit stalls
//   branch_taken_E, dest_pc_E             : execute-stage redirect
//   imem_req, imem_addr                   : fetch request (one cycle per fetch)
//   imem_rdata, imem_valid                : fetch response (variable latency)
//   instr_D, pc_D, pc_plus4D              : IF/ID register contents
//   fetch_busy                            : FSM is not in REQ
module fetch_pipeline #(
  parameter logic [15:0] RESET_PC  = 16'h0000,
  parameter logic [31:0] NOP_INSTR = fetch_pkg::NOP_INSTR
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pc_write_zero,
  input  logic        IF_pipeline_write_zero,
  input  logic        branch_taken_E,
  input  logic [15:0] dest_pc_E,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_valid,
  output logic [31:0] instr_D,
  output logic [15:0] pc_D,
  output logic [15:0] pc_plus4D,
  output logic        fetch_busy
);

  import fetch_pkg::*;

  fetch_state_t       state_q, state_d;
  logic [PC_W-1:0]    pc_q, pc_d;
  logic               drop_q, drop_d;
  logic [INSTR_W-1:0] buf_q, buf_d;
  logic [INSTR_W-1:0] ifid_instr_q, ifid_instr_d;
  logic [PC_W-1:0]    ifid_pc_q, ifid_pc_d;
  logic [PC_W-1:0]    ifid_pc4_q, ifid_pc4_d;

  logic [PC_W-1:0]    pc_plus4;
  logic               deliver_ok;

  // Wraps modulo 2^16 by width truncation.
  assign pc_plus4   = pc_q + PC_W'(4);
  assign deliver_ok = !IF_pipeline_write_zero && !pc_write_zero;

  // A redirect suppresses the request issued in the same cycle.
  assign imem_req   = (state_q == REQ) && !branch_taken_E && !reset;
  assign imem_addr  = pc_q;
  assign instr_D    = ifid_instr_q;
  assign pc_D       = ifid_pc_q;
  assign pc_plus4D  = ifid_pc4_q;
  assign fetch_busy = (state_q != REQ);

  // Next-state, PC, buffer and IF/ID update.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    drop_d       = drop_q;
    buf_d        = buf_q;
    // Empty slot inserts a bubble unless the IF/ID register is stalled.
    ifid_instr_d = IF_pipeline_write_zero ? ifid_instr_q : NOP_INSTR;
    ifid_pc_d    = ifid_pc_q;
    ifid_pc4_d   = ifid_pc4_q;

    if (branch_taken_E) begin
      // Redirect beats every stall and delivery.
      pc_d         = dest_pc_E;
      ifid_instr_d = NOP_INSTR;
      case (state_q)
        WAIT: begin
          if (imem_valid) begin
            drop_d  = 1'b0;
            state_d = REQ;
          end else begin
            // Response still in flight: remember to discard it.
            drop_d = 1'b1;
          end
        end
        default: state_d = REQ;
      endcase
    end else begin
      case (state_q)
        REQ: state_d = WAIT;
        WAIT: begin
          if (imem_valid) begin
            if (drop_q) begin
              drop_d  = 1'b0;
              state_d = REQ;
            end else if (deliver_ok) begin
              ifid_instr_d = imem_rdata;
              ifid_pc_d    = pc_q;
              ifid_pc4_d   = pc_plus4;
              pc_d         = pc_plus4;
              state_d      = REQ;
            end else begin
              buf_d   = imem_rdata;
              state_d = HOLD;
            end
          end
        end
        HOLD: begin
          if (deliver_ok) begin
            ifid_instr_d = buf_q;
            ifid_pc_d    = pc_q;
            ifid_pc4_d   = pc_plus4;
            pc_d         = pc_plus4;
            state_d      = REQ;
          end
        end
        default: state_d = REQ;
      endcase
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= REQ;
      pc_q         <= RESET_PC;
      drop_q       <= 1'b0;
      buf_q        <= '0;
      ifid_instr_q <= NOP_INSTR;
      ifid_pc_q    <= '0;
      ifid_pc4_q   <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      drop_q       <= drop_d;
      buf_q        <= buf_d;
      ifid_instr_q <= ifid_instr_d;
      ifid_pc_q    <= ifid_pc_d;
      ifid_pc4_q   <= ifid_pc4_d;
    end
  end

endmodule

// File: tb/tb_fetch_pipeline.sv
// Directed testbench for fetch_pipeline with a variable-latency memory model.
module tb_fetch_pipeline;

  localparam logic [31:0] NOP   = 32'h0000_0013;
  localparam logic [31:0] WORD0 = 32'h0050_0093;

  logic        clk;
  logic        reset;
  logic        pc_write_zero;
  logic        IF_pipeline_write_zero;
  logic        branch_taken_E;
  logic [15:0] dest_pc_E;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_valid;
  logic [31:0] instr_D;
  logic [15:0] pc_D;
  logic [15:0] pc_plus4D;
  logic        fetch_busy;

  int checks;
  int errors;

  int          mem_lat;
  bit          pend;
  int          cnt;
  logic [15:0] paddr;

  fetch_pipeline dut (
    .clk                    (clk),
    .reset                  (reset),
    .pc_write_zero          (pc_write_zero),
    .IF_pipeline_write_zero (IF_pipeline_write_zero),
    .branch_taken_E         (branch_taken_E),
    .dest_pc_E              (dest_pc_E),
    .imem_req               (imem_req),
    .imem_addr              (imem_addr),
    .imem_rdata             (imem_rdata),
    .imem_valid             (imem_valid),
    .instr_D                (instr_D),
    .pc_D                   (pc_D),
    .pc_plus4D              (pc_plus4D),
    .fetch_busy             (fetch_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] memf(input logic [15:0] a);
    if (a == 16'h0000) return WORD0;
    return {16'hC0DE, a};
  endfunction

  // Memory model: a request seen in cycle n answers with valid in cycle n+mem_lat.
  initial begin
    imem_valid = 1'b0;
    imem_rdata = '0;
    pend       = 1'b0;
    cnt        = 0;
    paddr      = '0;
    forever begin
      @(negedge clk);
      imem_valid = 1'b0;
      if (reset) begin
        pend = 1'b0;
      end else begin
        if (pend) begin
          cnt = cnt - 1;
          if (cnt == 0) begin
            imem_valid = 1'b1;
            imem_rdata = memf(paddr);
            pend       = 1'b0;
          end
        end
        if (imem_req) begin
          pend  = 1'b1;
          cnt   = mem_lat;
          paddr = imem_addr;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    pc_write_zero = 1'b0;
    IF_pipeline_write_zero = 1'b0;
    branch_taken_E = 1'b0;
    dest_pc_E = '0;
    mem_lat = 1;
    tick();
    tick();
    checks++; if (instr_D !== NOP) begin errors++; $display("FAIL reset_instr got %h want %h", instr_D, NOP); end
    checks++; if (pc_D !== 16'h0) begin errors++; $display("FAIL reset_pc_D got %h want 0000", pc_D); end
    checks++; if (pc_plus4D !== 16'h0) begin errors++; $display("FAIL reset_pc4 got %h want 0000", pc_plus4D); end
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL reset_req got %b want 0", imem_req); end
    checks++; if (fetch_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", fetch_busy); end
    reset = 1'b0;
    #1;
    checks++; if (imem_req !== 1'b1 || imem_addr !== 16'h0) begin errors++; $display("FAIL first_req got req=%b addr=%h want req=1 addr=0000", imem_req, imem_addr); end
  endtask

  task automatic test_basic_fetch();
    tick();
    checks++; if (fetch_busy !== 1'b1 || imem_req !== 1'b0) begin errors++; $display("FAIL wait_state got busy=%b req=%b want busy=1 req=0", fetch_busy, imem_req); end
    tick();
    checks++; if (instr_D !== WORD0 || pc_D !== 16'h0 || pc_plus4D !== 16'h4) begin errors++; $display("FAIL first_deliver got %h/%h/%h want %h/0000/0004", instr_D, pc_D, pc_plus4D, WORD0); end
    checks++; if (imem_req !== 1'b1 || imem_addr !== 16'h4) begin errors++; $display("FAIL second_req got req=%b addr=%h want req=1 addr=0004", imem_req, imem_addr); end
    tick();
    checks++; if (instr_D !== NOP || pc_D !== 16'h0) begin errors++; $display("FAIL empty_slot got %h pc_D=%h want %h pc_D=0000", instr_D, pc_D, NOP); end
    tick();
    checks++; if (instr_D !== 32'hC0DE0004 || pc_D !== 16'h4 || pc_plus4D !== 16'h8 || imem_addr !== 16'h8) begin errors++; $display("FAIL second_deliver got %h/%h/%h addr=%h want c0de0004/0004/0008 addr=0008", instr_D, pc_D, pc_plus4D, imem_addr); end
  endtask

  task automatic test_stall();
    pc_write_zero = 1'b1;
    IF_pipeline_write_zero = 1'b1;
    tick();
    checks++; if (instr_D !== 32'hC0DE0004) begin errors++; $display("FAIL stall_hold_wait got %h want c0de0004", instr_D); end
    tick();
    checks++; if (fetch_busy !== 1'b1 || imem_req !== 1'b0 || instr_D !== 32'hC0DE0004 || pc_D !== 16'h4) begin errors++; $display("FAIL stall_hold got busy=%b req=%b instr=%h pc_D=%h want 1/0/c0de0004/0004", fetch_busy, imem_req, instr_D, pc_D); end
    tick();
    pc_write_zero = 1'b0;
    IF_pipeline_write_zero = 1'b0;
    tick();
    checks++; if (instr_D !== 32'hC0DE0008 || pc_D !== 16'h8 || pc_plus4D !== 16'hC) begin errors++; $display("FAIL stall_release got %h/%h/%h want c0de0008/0008/000c", instr_D, pc_D, pc_plus4D); end
    checks++; if (imem_req !== 1'b1 || imem_addr !== 16'hC || fetch_busy !== 1'b0) begin errors++; $display("FAIL stall_next_req got req=%b addr=%h busy=%b want 1/000c/0", imem_req, imem_addr, fetch_busy); end
  endtask

  task automatic test_redirect_wait();
    mem_lat = 3;
    tick();
    branch_taken_E = 1'b1;
    dest_pc_E = 16'h0040;
    tick();
    branch_taken_E = 1'b0;
    checks++; if (instr_D !== NOP || fetch_busy !== 1'b1 || imem_req !== 1'b0 || imem_addr !== 16'h0040) begin errors++; $display("FAIL redir_wait got instr=%h busy=%b req=%b addr=%h want %h/1/0/0040", instr_D, fetch_busy, imem_req, imem_addr, NOP); end
    tick();
    tick();
    checks++; if (imem_req !== 1'b1 || imem_addr !== 16'h0040 || instr_D !== NOP || pc_D !== 16'h8) begin errors++; $display("FAIL redir_drop got req=%b addr=%h instr=%h pc_D=%h want 1/0040/%h/0008", imem_req, imem_addr, instr_D, pc_D, NOP); end
    for (int i = 0; i < 4; i++) tick();
    checks++; if (instr_D !== 32'hC0DE0040 || pc_D !== 16'h0040 || pc_plus4D !== 16'h0044 || imem_addr !== 16'h0044) begin errors++; $display("FAIL redir_target got %h/%h/%h addr=%h want c0de0040/0040/0044 addr=0044", instr_D, pc_D, pc_plus4D, imem_addr); end
  endtask

  task automatic test_redirect_hold();
    mem_lat = 1;
    pc_write_zero = 1'b1;
    IF_pipeline_write_zero = 1'b1;
    tick();
    tick();
    checks++; if (fetch_busy !== 1'b1 || instr_D !== 32'hC0DE0040) begin errors++; $display("FAIL hold_pre got busy=%b instr=%h want 1/c0de0040", fetch_busy, instr_D); end
    branch_taken_E = 1'b1;
    dest_pc_E = 16'h0080;
    tick();
    branch_taken_E = 1'b0;
    pc_write_zero = 1'b0;
    IF_pipeline_write_zero = 1'b0;
    #1;
    checks++; if (instr_D !== NOP || fetch_busy !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 16'h0080) begin errors++; $display("FAIL hold_flush got instr=%h busy=%b req=%b addr=%h want %h/0/1/0080", instr_D, fetch_busy, imem_req, imem_addr, NOP); end
    tick();
    tick();
    checks++; if (instr_D !== 32'hC0DE0080 || pc_D !== 16'h0080 || pc_plus4D !== 16'h0084) begin errors++; $display("FAIL hold_target got %h/%h/%h want c0de0080/0080/0084", instr_D, pc_D, pc_plus4D); end
  endtask

  task automatic test_pc_wrap();
    branch_taken_E = 1'b1;
    dest_pc_E = 16'hFFFC;
    #1;
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL redir_req_suppress got %b want 0", imem_req); end
    tick();
    branch_taken_E = 1'b0;
    #1;
    checks++; if (imem_req !== 1'b1 || imem_addr !== 16'hFFFC || instr_D !== NOP) begin errors++; $display("FAIL wrap_req got req=%b addr=%h instr=%h want 1/fffc/%h", imem_req, imem_addr, instr_D, NOP); end
    tick();
    tick();
    checks++; if (instr_D !== 32'hC0DEFFFC || pc_D !== 16'hFFFC || pc_plus4D !== 16'h0000 || imem_addr !== 16'h0000) begin errors++; $display("FAIL wrap_deliver got %h/%h/%h addr=%h want c0defffc/fffc/0000 addr=0000", instr_D, pc_D, pc_plus4D, imem_addr); end
  endtask

  task automatic test_async_reset();
    mem_lat = 3;
    tick();
    checks++; if (fetch_busy !== 1'b1) begin errors++; $display("FAIL areset_pre got busy=%b want 1", fetch_busy); end
    #2;
    reset = 1'b1;
    #1;
    checks++; if (instr_D !== NOP || pc_D !== 16'h0 || pc_plus4D !== 16'h0 || fetch_busy !== 1'b0 || imem_req !== 1'b0) begin errors++; $display("FAIL areset_now got instr=%h pc_D=%h pc4=%h busy=%b req=%b want %h/0000/0000/0/0", instr_D, pc_D, pc_plus4D, fetch_busy, imem_req, NOP); end
    mem_lat = 1;
    tick();
    tick();
    reset = 1'b0;
    #1;
    checks++; if (imem_req !== 1'b1 || imem_addr !== 16'h0) begin errors++; $display("FAIL areset_req got req=%b addr=%h want 1/0000", imem_req, imem_addr); end
    tick();
    tick();
    checks++; if (instr_D !== WORD0 || pc_D !== 16'h0 || pc_plus4D !== 16'h4) begin errors++; $display("FAIL areset_deliver got %h/%h/%h want %h/0000/0004", instr_D, pc_D, pc_plus4D, WORD0); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_basic_fetch();
    test_stall();
    test_redirect_wait();
    test_redirect_hold();
    test_pc_wrap();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_pipeline.md
Name: fetch_pipeline

Overview:
- Instruction-fetch stage and IF/ID pipeline register; producer of instr_D, pc_D and pc_plus4D for the decode stage.
- Owns the 16-bit PC and issues requests to a variable-latency instruction memory (req/valid handshake).
- Honours the decode-stage hazard stalls (pc_write_zero, IF_pipeline_write_zero) and the execute-stage branch redirect (branch_taken_E, dest_pc_E).
- Flushes with NOP bubbles on every redirect.

Parameters:
RESET_PC, 16'h0000, PC value loaded on reset
NOP_INSTR, 32'h00000013, bubble instruction (addi x0,x0,0) driven on flush or empty slot

Ports:
clk  input  1  clock
reset  input  1  reset, asynchronous, active-high
pc_write_zero  input  1  hazard unit: hold PC this cycle
IF_pipeline_write_zero  input  1  hazard unit: hold IF/ID register this cycle
branch_taken_E  input  1  execute stage: redirect to dest_pc_E
dest_pc_E  input  16  redirect target
imem_req  output  1  request strobe, one cycle per fetch
imem_addr  output  16  fetch address, equals current PC
imem_rdata  input  32  returned instruction
imem_valid  input  1  imem_rdata valid; earliest the cycle after imem_req
instr_D  output  32  IF/ID instruction
pc_D  output  16  IF/ID PC
pc_plus4D  output  16  IF/ID PC+4
fetch_busy  output  1  high when state != REQ

Behaviour:
- Reset, asynchronous:
  - pc=RESET_PC, state=REQ, drop=0, buffer cleared.
  - instr_D=NOP_INSTR, pc_D=0, pc_plus4D=0.
  - imem_req forced 0 while reset is high.
- State REQ:
  - imem_req = !branch_taken_E; imem_addr = pc.
  - Next state is WAIT if a request was issued. On redirect, stay in REQ with pc=dest_pc_E.
- State WAIT: wait for imem_valid.
  - drop=1 at imem_valid: discard the response, clear drop, go to REQ.
  - Otherwise, deliver when IF_pipeline_write_zero=0 and pc_write_zero=0:
    - IF/ID <= {imem_rdata, pc, pc+4}.
    - pc <= pc+4.
    - Go to REQ.
  - Otherwise: capture imem_rdata into the one-entry buffer and go to HOLD.
- State HOLD:
  - When both stalls are low: IF/ID <= {buffer, pc, pc+4}, pc <= pc+4, go to REQ.
- Empty slot: if the IF/ID register is not stalled and nothing is delivered this cycle, instr_D <= NOP_INSTR; pc_D and pc_plus4D hold.
- IF_pipeline_write_zero=1 with no flush: all IF/ID fields hold.
- Redirect (branch_taken_E=1) has priority over every stall and delivery:
  - pc <= dest_pc_E, used as-is with no alignment check.
  - instr_D <= NOP_INSTR.
  - In WAIT with imem_valid low: set drop=1 and stay in WAIT.
  - In WAIT with imem_valid high: discard the response and go to REQ.
  - In HOLD: discard the buffer and go to REQ.
- Arithmetic: pc+4 is modulo 2^16, so 16'hFFFC -> 16'h0000.
- Latency and throughput:
  - Memory latency L cycles (L>=1) gives instr_D updating on the edge after imem_valid.
  - Peak rate is one instruction per 2 cycles.
- Only one request is outstanding at a time; imem_req never asserts in WAIT or HOLD.
- Reset mid-transaction aborts the request. The instruction memory shares the same reset, so no stale response arrives.

Decomposition:
- Shared package fetch_pkg:
  - NOP_INSTR constant.
  - PC_W=16.
  - Enum fetch_state_t {REQ, WAIT, HOLD}.
- No sub-module. The FSM, PC register, one-entry buffer and IF/ID register live in one module.

Test Plan:
- Reset then L=1 memory returning 0x00500093 at addr 0 -> imem_req at cycle 0; instr_D=0x00500093, pc_D=0, pc_plus4D=4 after the valid edge; next imem_addr=4.
- Stall: IF_pipeline_write_zero=pc_write_zero=1 for 3 cycles when the response arrives -> state HOLD, IF/ID holds; on release, instr_D = the buffered word and pc advances by 4.
- Redirect in WAIT (L=3): branch_taken_E=1, dest_pc_E=0x0040 one cycle after req -> instr_D=NOP, response discarded, next imem_addr=0x0040.
- Redirect in HOLD while stalled -> flush overrides the stall: instr_D=NOP, buffer dropped, fetch from dest_pc_E.
- PC wrap: redirect to 0xFFFC, memory returns X -> pc_D=0xFFFC, pc_plus4D=0x0000, next imem_addr=0x0000.
- Async reset asserted in WAIT -> outputs return to reset values immediately, imem_req=0; after release, first request is at RESET_PC.
